pll_dlf_pi: RTL and testbench
=============================

Name: pll_dlf_pi

Overview:
- Clocked, parametrised digital loop filter for the all-digital PLL variant. Next generation of the passive analog loop filter, which fixes R/C1/C2 and gives one output mode.
- Takes a signed phase-error sample per reference cycle. Produces an unsigned DCO control code from a proportional path, an integral path and an optional extra pole.
- Adds programmable gains, anti-windup, freeze, direct code load and saturation flags.
- Sits between the TDC/BBPD error quantiser and the DCO model.

Parameters:
- IN_W, 8, width of the signed phase-error input.
- OUT_W, 10, width of the unsigned DCO code.
- FRAC_W, 8, fractional bits carried in the integrator and pole state.
- ACC_W, 24, signed state width. Must be >= max(OUT_W+FRAC_W+2, IN_W+16); elaboration error otherwise.
- INIT_CODE, 512, DCO code after reset.

Ports:
- clk  in  1  reference-rate clock.
- rstb  in  1  asynchronous active-low reset.
- in_vld  in  1  err sample valid this cycle.
- err  in  IN_W  signed phase error.
- kp_sh  in  4  proportional gain, 2^kp_sh.
- ki_sh  in  4  integral gain, 2^ki_sh.
- mode  in  2  00 P-only (integrator held), 01 PI, 10 PI+pole, 11 treated as 01.
- pole_sh  in  3  pole coefficient 2^-pole_sh, 0 = bypass.
- freeze  in  1  hold the integrator; proportional path stays live.
- load  in  1  force the state to load_val.
- load_val  in  OUT_W  code to load.
- out_vld  out  1  code updated this cycle.
- code  out  OUT_W  DCO control code.
- sat_hi  out  1  last output clamped at 2^OUT_W-1.
- sat_lo  out  1  last output clamped at 0.

Behaviour:
- Reset (rstb low, async):
  - acc = y = INIT_CODE<<FRAC_W; stage-1 register sum = same.
  - code = INIT_CODE; out_vld = sat_hi = sat_lo = 0; pipeline valid cleared.
- Stage 1, on in_vld:
  - p = sext(err)<<<kp_sh; inc = sext(err)<<<ki_sh, all at ACC_W.
  - acc_n = acc+inc if mode is PI/PI+pole and freeze=0; otherwise acc_n = acc.
  - acc_n is clamped to [0, (2^OUT_W-1)<<FRAC_W] (anti-windup). acc <= acc_n.
  - sum <= acc_n+p, unclamped. v1 <= 1.
- Stage 2, on v1:
  - mode 10 with pole_sh!=0: y <= y + ((sum-y)>>>pole_sh), arithmetic shift.
  - All other modes: y <= sum.
  - r = (y_new + 2^(FRAC_W-1))>>>FRAC_W (round half up).
  - code <= clamp(r, 0, 2^OUT_W-1).
  - sat_hi/sat_lo <= 1 when the clamp hit that bound, else 0.
  - out_vld <= 1 for exactly one cycle.
- Latency: in_vld in cycle n gives out_vld/code in cycle n+2. Throughput is one sample per cycle. Back-to-back samples are fully pipelined.
- Without in_vld: acc, y and code hold; out_vld = 0.
- Load (priority over in_vld):
  - acc = y = sum <= load_val<<FRAC_W; code <= load_val next cycle.
  - v1 is cleared, so an in-flight sample is dropped and out_vld = 0 in the cycle after load.
  - A sample with in_vld in the load cycle is discarded.
- Mode, gain and pole changes take effect on the next accepted sample.
  - y tracks sum in non-pole modes, so entering pole mode is bumpless.
  - Leaving pole mode snaps y to sum.
- freeze during P-only has no extra effect.
- kp_sh/ki_sh up to 15 never overflow, by the ACC_W rule.
- Negative sum/y are legal internally; only code is clamped.

Decomposition:
- Package pll_dlf_pkg holds:
  - mode encodings (DLF_P, DLF_PI, DLF_PIP);
  - the ACC_W legality check function;
  - a clamp/round function shared with the existing testbench scoreboard.
- One sub-module, dlf_sat_round: y to code, sat_hi, sat_lo. Combinational, reused by a future multi-channel variant.
- Integrator and pole state stay in the top.

Test Plan:
- All scenarios use default parameters.
- Reset: assert rstb low mid-stream with samples in flight -> code=512, out_vld=0 and flags 0 immediately. First output after release is computed from acc = 131072.
- PI impulse: mode=01, kp_sh=4, ki_sh=0, err=+16 one sample, then err=0 -> out_vld two cycles after each in_vld; code=513, then 512 (acc=131088).
- Windup: ki_sh=12, err=+127 for 4 samples -> acc clamps at 261888, code=1023, sat_hi=1. Then kp_sh=ki_sh=0, err=-1 -> code=1023, sat_hi=0.
- Freeze: freeze=1, mode=01, kp_sh=4, ki_sh=4, err=+16 for 3 samples, then err=0 -> code=513 while err is applied, 512 after; acc unchanged at 131072.
- Load collision: load=1, load_val=300, in_vld=1 in the same cycle, with a sample in flight -> code=300 next cycle, no out_vld that cycle. Subsequent err=0 samples output 300.
- Pole step: mode=10, pole_sh=2, freeze=1, kp_sh=12, constant err=+8 from steady 512 -> successive code 544, 568, 586, converging to 640.

Source files
------------

// File: rtl/pll_dlf_pkg.sv
// Shared definitions for the PI digital loop filter: mode encodings,
// the state-width legality rule and a reference round/clamp helper.
package pll_dlf_pkg;

  typedef enum logic [1:0] {
    DLF_P      = 2'b00,  // proportional only, integrator held
    DLF_PI     = 2'b01,  // proportional + integral
    DLF_PIP    = 2'b10,  // PI plus single extra pole
    DLF_PI_ALT = 2'b11   // behaves as DLF_PI
  } dlf_mode_e;

  // State must hold the clamped integrator plus a full 15-bit-shifted error.
  function automatic bit acc_w_legal(input int acc_w, input int out_w,
                                     input int frac_w, input int in_w);
    int a;
    int b;
    a = out_w + frac_w + 2;
    b = in_w + 16;
    return acc_w >= ((a > b) ? a : b);
  endfunction

  // Round half up from FRAC_W fractional bits, then clamp to the code range.
  function automatic longint dlf_round_clamp(input longint y, input int frac_w,
                                             input int out_w);
    longint r;
    longint cmax;
    r    = (y + (longint'(1) <<< (frac_w - 1))) >>> frac_w;
    cmax = (longint'(1) <<< out_w) - 1;
    if (r < 0)    return 0;
    if (r > cmax) return cmax;
    return r;
  endfunction

endpackage

// File: rtl/dlf_sat_round.sv
// Fixed-point filter state to DCO code: round half up, clamp, flag the clamp.
module dlf_sat_round
  import pll_dlf_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 10,
  parameter int FRAC_W = 8
) (
  input  logic signed [ACC_W-1:0] y,
  output logic        [OUT_W-1:0] code,
  output logic                    sat_hi,
  output logic                    sat_lo
);

  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) <<< (FRAC_W - 1);
  localparam logic signed [ACC_W:0] CMAX = (ACC_W+1)'((2**OUT_W) - 1);

  // One guard bit so adding the half LSB can never wrap.
  logic signed [ACC_W:0] y_rnd;
  logic signed [ACC_W:0] r;

  assign y_rnd = $signed({y[ACC_W-1], y}) + HALF;
  assign r     = y_rnd >>> FRAC_W;

  // Clamp to [0, 2^OUT_W-1]; a value landing exactly on a bound is not a clamp.
  always_comb begin
    code   = r[OUT_W-1:0];
    sat_hi = 1'b0;
    sat_lo = 1'b0;
    if (r < 0) begin
      code   = '0;
      sat_lo = 1'b1;
    end else if (r > CMAX) begin
      code   = '1;
      sat_hi = 1'b1;
    end
  end

endmodule

// File: rtl/pll_dlf_pi.sv
// Two-stage PI(+pole) digital loop filter: phase error in, unsigned DCO code out.
// Stage 1 updates the anti-windup integrator and forms sum = acc + p;
// stage 2 optionally low-passes sum through the pole and rounds to the code.
module pll_dlf_pi
  import pll_dlf_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 10,
  parameter int FRAC_W    = 8,
  parameter int ACC_W     = 24,
  parameter int INIT_CODE = 512
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   in_vld,
  input  logic signed [IN_W-1:0] err,
  input  logic        [3:0]      kp_sh,
  input  logic        [3:0]      ki_sh,
  input  logic        [1:0]      mode,
  input  logic        [2:0]      pole_sh,
  input  logic                   freeze,
  input  logic                   load,
  input  logic        [OUT_W-1:0] load_val,
  output logic                   out_vld,
  output logic        [OUT_W-1:0] code,
  output logic                   sat_hi,
  output logic                   sat_lo
);

  if (!acc_w_legal(ACC_W, OUT_W, FRAC_W, IN_W)) begin : g_acc_w_chk
    $error("pll_dlf_pi: ACC_W too narrow for OUT_W/FRAC_W/IN_W");
  end

  localparam logic signed [ACC_W-1:0] INIT_Q  = ACC_W'(INIT_CODE) <<< FRAC_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((2**OUT_W) - 1) <<< FRAC_W;

  logic signed [ACC_W-1:0] acc, sum, y;
  logic signed [ACC_W-1:0] err_x, p, inc, acc_add, acc_n, load_q, y_new;
  logic signed [ACC_W:0]   diff, step, y_step;
  logic                    v1, pole_q, integ_en;
  logic        [2:0]       sh_q;
  logic        [OUT_W-1:0] code_n;
  logic                    hi_n, lo_n;

  assign err_x    = {{(ACC_W-IN_W){err[IN_W-1]}}, err};
  assign p        = err_x <<< kp_sh;
  assign inc      = err_x <<< ki_sh;
  assign integ_en = (mode != DLF_P) && !freeze;
  assign load_q   = ACC_W'(load_val) <<< FRAC_W;

  // Integrator update with anti-windup clamp to the representable code range.
  always_comb begin
    acc_add = acc + (integ_en ? inc : '0);
    acc_n   = acc_add;
    if (acc_add < 0)            acc_n = '0;
    else if (acc_add > ACC_MAX) acc_n = ACC_MAX;
  end

  // Pole: y += (sum - y) >>> sh. Difference carried one bit wider since sum
  // and y may sit at opposite ends of their range; the result lies between
  // them and so always fits back into ACC_W bits.
  assign diff   = $signed({sum[ACC_W-1], sum}) - $signed({y[ACC_W-1], y});
  assign step   = diff >>> sh_q;
  assign y_step = $signed({y[ACC_W-1], y}) + step;
  assign y_new  = pole_q ? y_step[ACC_W-1:0] : sum;

  dlf_sat_round #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .FRAC_W(FRAC_W)
  ) u_sat_round (
    .y     (y_new),
    .code  (code_n),
    .sat_hi(hi_n),
    .sat_lo(lo_n)
  );

  // Stage 1: integrator, unclamped proportional sum, pole settings for stage 2.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      acc    <= INIT_Q;
      sum    <= INIT_Q;
      v1     <= 1'b0;
      pole_q <= 1'b0;
      sh_q   <= '0;
    end else if (load) begin
      acc <= load_q;
      sum <= load_q;
      v1  <= 1'b0;
    end else begin
      v1 <= in_vld;
      if (in_vld) begin
        acc    <= acc_n;
        sum    <= acc_n + p;
        pole_q <= (mode == DLF_PIP) && (pole_sh != 3'd0);
        sh_q   <= pole_sh;
      end
    end
  end

  // Stage 2: pole state, registered code and clamp flags, one-cycle out_vld.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      y       <= INIT_Q;
      code    <= OUT_W'(INIT_CODE);
      out_vld <= 1'b0;
      sat_hi  <= 1'b0;
      sat_lo  <= 1'b0;
    end else if (load) begin
      y       <= load_q;
      code    <= load_val;
      out_vld <= 1'b0;
      sat_hi  <= 1'b0;
      sat_lo  <= 1'b0;
    end else begin
      out_vld <= v1;
      if (v1) begin
        y      <= y_new;
        code   <= code_n;
        sat_hi <= hi_n;
        sat_lo <= lo_n;
      end
    end
  end

endmodule

// File: tb/tb_pll_dlf_pi.sv
// Directed, table-driven bench for pll_dlf_pi with hand-computed codes.
module tb_pll_dlf_pi;
  import pll_dlf_pkg::*;

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic              in_vld = 1'b0;
  logic signed [7:0] err = '0;
  logic        [3:0] kp_sh = '0;
  logic        [3:0] ki_sh = '0;
  logic        [1:0] mode = 2'b01;
  logic        [2:0] pole_sh = '0;
  logic              freeze = 1'b0;
  logic              load = 1'b0;
  logic        [9:0] load_val = '0;
  logic              out_vld;
  logic        [9:0] code;
  logic              sat_hi;
  logic              sat_lo;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    int ld, ldv, iv, e, kp, ki, md, ps, fz;  // inputs for one cycle
    int xv, xc, xh, xl;                      // outputs after that cycle's edge
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  pll_dlf_pi dut (
    .clk     (clk),
    .rstb    (rstb),
    .in_vld  (in_vld),
    .err     (err),
    .kp_sh   (kp_sh),
    .ki_sh   (ki_sh),
    .mode    (mode),
    .pole_sh (pole_sh),
    .freeze  (freeze),
    .load    (load),
    .load_val(load_val),
    .out_vld (out_vld),
    .code    (code),
    .sat_hi  (sat_hi),
    .sat_lo  (sat_lo)
  );

  function automatic vec_t mk(int ld, int ldv, int iv, int e, int kp, int ki,
                              int md, int ps, int fz, int xv, int xc, int xh, int xl);
    vec_t v;
    v.ld = ld; v.ldv = ldv; v.iv = iv; v.e = e; v.kp = kp; v.ki = ki;
    v.md = md; v.ps = ps; v.fz = fz;
    v.xv = xv; v.xc = xc; v.xh = xh; v.xl = xl;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_out(input string tag, input int xv, input int xc,
                         input int xh, input int xl);
    chk({tag, " out_vld"}, int'(out_vld), xv);
    chk({tag, " code"},    int'(code),    xc);
    chk({tag, " sat_hi"},  int'(sat_hi),  xh);
    chk({tag, " sat_lo"},  int'(sat_lo),  xl);
  endtask

  task automatic drive(input vec_t v);
    load     = v.ld[0];
    load_val = 10'(v.ldv);
    in_vld   = v.iv[0];
    err      = 8'(v.e);
    kp_sh    = 4'(v.kp);
    ki_sh    = 4'(v.ki);
    mode     = 2'(v.md);
    pole_sh  = 3'(v.ps);
    freeze   = v.fz[0];
  endtask

  initial begin
    // PI impulse from reset state (acc = 131072)
    tbl.push_back(mk(0,0,  1, 16, 4, 0, 1,0,0,  0, 512,0,0));
    tbl.push_back(mk(0,0,  1,  0, 4, 0, 1,0,0,  1, 513,0,0));
    tbl.push_back(mk(0,0,  0,  0, 4, 0, 1,0,0,  1, 512,0,0));
    tbl.push_back(mk(0,0,  0,  0, 4, 0, 1,0,0,  0, 512,0,0));
    // windup: integrator clamps at 261888, p pushes code past the top
    tbl.push_back(mk(0,0,  1,127, 4,12, 1,0,0,  0, 512,0,0));
    tbl.push_back(mk(0,0,  1,127, 4,12, 1,0,0,  1,1023,1,0));
    tbl.push_back(mk(0,0,  1,127, 4,12, 1,0,0,  1,1023,1,0));
    tbl.push_back(mk(0,0,  1,127, 4,12, 1,0,0,  1,1023,1,0));
    tbl.push_back(mk(0,0,  1, -1, 0, 0, 1,0,0,  1,1023,1,0));
    tbl.push_back(mk(0,0,  0,  0, 0, 0, 1,0,0,  1,1023,0,0));
    tbl.push_back(mk(0,0,  0,  0, 0, 0, 1,0,0,  0,1023,0,0));
    // reload 512, then frozen integrator
    tbl.push_back(mk(1,512,0,  0, 0, 0, 1,0,0,  0, 512,0,0));
    tbl.push_back(mk(0,0,  1, 16, 4, 4, 1,0,1,  0, 512,0,0));
    tbl.push_back(mk(0,0,  1, 16, 4, 4, 1,0,1,  1, 513,0,0));
    tbl.push_back(mk(0,0,  1, 16, 4, 4, 1,0,1,  1, 513,0,0));
    tbl.push_back(mk(0,0,  1,  0, 4, 4, 1,0,1,  1, 513,0,0));
    tbl.push_back(mk(0,0,  0,  0, 4, 4, 1,0,1,  1, 512,0,0));
    tbl.push_back(mk(0,0,  1,  0, 0, 0, 1,0,0,  0, 512,0,0));
    tbl.push_back(mk(0,0,  0,  0, 0, 0, 1,0,0,  1, 512,0,0));
    // load collides with an in-flight sample and a same-cycle sample
    tbl.push_back(mk(0,0,  1, 16, 4, 0, 1,0,0,  0, 512,0,0));
    tbl.push_back(mk(1,300,1, 16, 4, 0, 1,0,0,  0, 300,0,0));
    tbl.push_back(mk(0,0,  0,  0, 4, 0, 1,0,0,  0, 300,0,0));
    tbl.push_back(mk(0,0,  1,  0, 4, 0, 1,0,0,  0, 300,0,0));
    tbl.push_back(mk(0,0,  1,  0, 4, 0, 1,0,0,  1, 300,0,0));
    tbl.push_back(mk(0,0,  0,  0, 4, 0, 1,0,0,  1, 300,0,0));
    tbl.push_back(mk(0,0,  0,  0, 4, 0, 1,0,0,  0, 300,0,0));
    // low clamp: load 0, negative error drives sum below zero
    tbl.push_back(mk(1,0,  0,  0, 4, 0, 1,0,0,  0,   0,0,0));
    tbl.push_back(mk(0,0,  1,-128,4, 0, 1,0,0,  0,   0,0,0));
    tbl.push_back(mk(0,0,  1,  0, 4, 0, 1,0,0,  1,   0,0,1));
    tbl.push_back(mk(0,0,  0,  0, 4, 0, 1,0,0,  1,   0,0,0));
    tbl.push_back(mk(0,0,  0,  0, 4, 0, 1,0,0,  0,   0,0,0));
    // pole step from 512 toward 640
    tbl.push_back(mk(1,512,0,  0, 0, 0, 1,0,0,  0, 512,0,0));
    tbl.push_back(mk(0,0,  1,  8,12, 0, 2,2,1,  0, 512,0,0));
    tbl.push_back(mk(0,0,  1,  8,12, 0, 2,2,1,  1, 544,0,0));
    tbl.push_back(mk(0,0,  1,  8,12, 0, 2,2,1,  1, 568,0,0));
    tbl.push_back(mk(0,0,  1,  8,12, 0, 2,2,1,  1, 586,0,0));

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset held", 0, 512, 0, 0);
    rstb = 1'b1;
    @(posedge clk); #1;
    chk_out("reset idle", 0, 512, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      chk_out($sformatf("row%0d", i), tbl[i].xv, tbl[i].xc, tbl[i].xh, tbl[i].xl);
    end

    // pole keeps converging while the same error is applied
    repeat (40) @(posedge clk);
    #1;
    chk_out("pole settled", 1, 640, 0, 0);

    // asynchronous reset with samples still in flight
    @(posedge clk); #3;
    rstb = 1'b0;
    #1;
    chk_out("async reset", 0, 512, 0, 0);
    #2;
    rstb    = 1'b1;
    mode    = 2'b01;
    kp_sh   = 4'd4;
    ki_sh   = 4'd0;
    freeze  = 1'b0;
    pole_sh = 3'd0;
    err     = 8'sd16;
    in_vld  = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    chk_out("post reset lat1", 0, 512, 0, 0);
    @(posedge clk); #1;
    chk_out("post reset lat2", 1, 513, 0, 0);
    @(posedge clk); #1;
    chk_out("post reset idle", 0, 513, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
